id_fwd_stage: RTL and testbench

ID_FWD_STAGE -- requirements
Module: id_fwd_stage

---
 rtl/id_fwd_stage.sv | 127 ++++++++++++
 tb/tb_id_fwd_stage.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_fwd_stage.sv
// Decode-to-execute stage register with operand forwarding, load-use stall
// detection and saturating stall/flush counters.
module id_fwd_stage #(
    parameter int XLEN   = 32,
    parameter int NFWD   = 3,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        pc_in,
    input  logic [XLEN-1:0]        imm_in,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [4:0]             rd,
    input  logic [CTRL_W-1:0]      ctrl_in,
    input  logic                   reg_write_in,
    input  logic                   mem_read_in,
    input  logic [XLEN-1:0]        rf_rd1,
    input  logic [XLEN-1:0]        rf_rd2,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_pending,
    input  logic [5*NFWD-1:0]      fwd_addr,
    input  logic [XLEN*NFWD-1:0]   fwd_data,
    input  logic                   flush,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_imm,
    output logic [XLEN-1:0]        out_rd1,
    output logic [XLEN-1:0]        out_rd2,
    output logic [4:0]             out_rd,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic                   out_reg_write,
    output logic                   out_mem_read,
    output logic                   hazard,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] op1, op2;
    logic            pend1, pend2;
    logic            adv, load;

    // Walk oldest to youngest so the youngest matching channel overwrites.
    always_comb begin
        op1   = rf_rd1;
        op2   = rf_rd2;
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*5 +: 5] == rs1)) begin
                op1   = fwd_data[i*XLEN +: XLEN];
                pend1 = fwd_pending[i];
            end
            if (fwd_valid[i] && (fwd_addr[i*5 +: 5] == rs2)) begin
                op2   = fwd_data[i*XLEN +: XLEN];
                pend2 = fwd_pending[i];
            end
        end
        if (rs1 == 5'd0) begin
            op1   = '0;
            pend1 = 1'b0;
        end
        if (rs2 == 5'd0) begin
            op2   = '0;
            pend2 = 1'b0;
        end
    end

    assign hazard   = in_valid & (pend1 | pend2);
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~hazard & ~flush;
    assign load     = in_valid & in_ready;

    // Every bubble clears the data fields, which covers the hazard case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_imm       <= '0;
            out_rd1       <= '0;
            out_rd2       <= '0;
            out_rd        <= '0;
            out_ctrl      <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else if (flush || (adv && !load)) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_imm       <= '0;
            out_rd1       <= '0;
            out_rd2       <= '0;
            out_rd        <= '0;
            out_ctrl      <= '0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            out_pc        <= pc_in;
            out_imm       <= imm_in;
            out_rd1       <= op1;
            out_rd2       <= op2;
            out_rd        <= rd;
            out_ctrl      <= ctrl_in;
            out_reg_write <= reg_write_in;
            out_mem_read  <= mem_read_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && !flush && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && out_valid && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Scoreboard bench for id_fwd_stage: expected stage contents are queued when an
// instruction is offered and compared while the DUT holds and hands them on.
module tb_id_fwd_stage;

    localparam int XLEN   = 32;
    localparam int NFWD   = 3;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 2;
    localparam logic [CNT_W-1:0] SAT = '1;

    typedef struct {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
        logic              rw;
        logic              mr;
    } rec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready;
    logic [XLEN-1:0]      pc_in, imm_in, rf_rd1, rf_rd2;
    logic [4:0]           rs1, rs2, rd;
    logic [CTRL_W-1:0]    ctrl_in;
    logic                 reg_write_in, mem_read_in;
    logic [NFWD-1:0]      fwd_valid, fwd_pending;
    logic [5*NFWD-1:0]    fwd_addr;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic                 flush, out_ready;
    logic                 out_valid;
    logic [XLEN-1:0]      out_pc, out_imm, out_rd1, out_rd2;
    logic [4:0]           out_rd;
    logic [CTRL_W-1:0]    out_ctrl;
    logic                 out_reg_write, out_mem_read;
    logic                 hazard;
    logic [CNT_W-1:0]     stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rec_t             q[$];
    logic             mv;
    logic             zero_exp;
    logic [CNT_W-1:0] sc, fc;

    id_fwd_stage #(.XLEN(XLEN), .NFWD(NFWD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .imm_in(imm_in),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .ctrl_in(ctrl_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_imm(out_imm),
        .out_rd1(out_rd1), .out_rd2(out_rd2), .out_rd(out_rd),
        .out_ctrl(out_ctrl), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .hazard(hazard), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model_op(input logic [4:0] rs, input logic [XLEN-1:0] rf,
                                                 output logic pend);
        pend = 1'b0;
        if (rs == 5'd0) return '0;
        for (int i = 0; i < NFWD; i++) begin
            if (fwd_valid[i] && fwd_addr[i*5 +: 5] == rs) begin
                pend = fwd_pending[i];
                return fwd_data[i*XLEN +: XLEN];
            end
        end
        return rf;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == SAT) ? v : v + 1'b1;
    endfunction

    task automatic check_rec(input string tag, input rec_t r);
        check_val({tag, ".pc"},   out_pc, r.pc);
        check_val({tag, ".imm"},  out_imm, r.imm);
        check_val({tag, ".rd1"},  out_rd1, r.rd1);
        check_val({tag, ".rd2"},  out_rd2, r.rd2);
        check_val({tag, ".rd"},   out_rd, r.rd);
        check_val({tag, ".ctrl"}, out_ctrl, r.ctrl);
        check_val({tag, ".rw"},   out_reg_write, r.rw);
        check_val({tag, ".mr"},   out_mem_read, r.mr);
    endtask

    task automatic check_zero(input string tag);
        rec_t z;
        z = '{pc: '0, imm: '0, rd1: '0, rd2: '0, rd: '0, ctrl: '0, rw: 1'b0, mr: 1'b0};
        check_rec(tag, z);
    endtask

    task automatic set_fwd(input int i, input logic v, input logic p, input logic [4:0] a,
                           input logic [XLEN-1:0] d);
        fwd_valid[i]           = v;
        fwd_pending[i]         = p;
        fwd_addr[i*5 +: 5]     = a;
        fwd_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic clear_fwd();
        fwd_valid   = '0;
        fwd_pending = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
    endtask

    task automatic new_instr(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d);
        in_valid     = 1'b1;
        pc_in        = $urandom;
        imm_in       = $urandom;
        ctrl_in      = CTRL_W'($urandom);
        reg_write_in = 1'($urandom);
        mem_read_in  = 1'($urandom);
        rf_rd1       = $urandom;
        rf_rd2       = $urandom;
        rs1          = a1;
        rs2          = a2;
        rd           = d;
    endtask

    task automatic model_reset();
        mv = 1'b0;
        zero_exp = 1'b1;
        sc = '0;
        fc = '0;
        q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".out_valid"}, out_valid, 1'b0);
        check_zero(tag);
        check_val({tag, ".stall_cnt"}, stall_cnt, '0);
        check_val({tag, ".flush_cnt"}, flush_cnt, '0);
    endtask

    // One clock with reset released: predict, compare combinational outputs,
    // advance the scoreboard, then compare registered outputs after the edge.
    task automatic cycle();
        logic p1, p2, hz, adv, ir;
        logic [XLEN-1:0] o1, o2;
        rec_t r;
        #1;
        o1  = model_op(rs1, rf_rd1, p1);
        o2  = model_op(rs2, rf_rd2, p2);
        hz  = in_valid && (p1 || p2);
        adv = !mv || out_ready;
        ir  = adv && !hz && !flush;
        check_val("hazard", hazard, hz);
        check_val("in_ready", in_ready, ir);
        if (mv && out_ready && !flush) begin
            r = q.pop_front();
            check_rec("xfer", r);
        end
        if (hz && !flush) sc = sat_inc(sc);
        if (flush) begin
            if (mv) fc = sat_inc(fc);
            q.delete();
            mv = 1'b0;
            zero_exp = 1'b1;
        end else if (in_valid && ir) begin
            r = '{pc: pc_in, imm: imm_in, rd1: o1, rd2: o2, rd: rd, ctrl: ctrl_in,
                  rw: reg_write_in, mr: mem_read_in};
            q.push_back(r);
            mv = 1'b1;
            zero_exp = 1'b0;
        end else if (adv) begin
            mv = 1'b0;
            zero_exp = hz;
        end
        @(posedge clk);
        #1;
        check_val("out_valid", out_valid, mv);
        if (mv && q.size() > 0) check_rec("stage", q[0]);
        else if (!mv && zero_exp) check_zero("bubble");
        check_val("stall_cnt", stall_cnt, sc);
        check_val("flush_cnt", flush_cnt, fc);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; pc_in = '0; imm_in = '0; rs1 = '0; rs2 = '0; rd = '0;
        ctrl_in = '0; reg_write_in = 1'b0; mem_read_in = 1'b0;
        rf_rd1 = '0; rf_rd2 = '0;
        flush = 1'b0; out_ready = 1'b1;
        clear_fwd();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        check_val("reset.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Youngest of two matching channels wins
        new_instr(5'd5, 5'd0, 5'd3);
        rf_rd1 = 32'h11;
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'hAA);
        set_fwd(1, 1'b1, 1'b0, 5'd5, 32'hBB);
        cycle();
        check_val("prio.rd1", out_rd1, 32'hAA);
        check_val("prio.valid", out_valid, 1'b1);

        // x0 never forwards and never stalls, rd==0 with reg_write passes through
        clear_fwd();
        new_instr(5'd0, 5'd3, 5'd0);
        reg_write_in = 1'b1;
        set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hFF);
        cycle();
        check_val("x0.rd1", out_rd1, 32'h0);
        check_val("x0.rw", out_reg_write, 1'b1);

        // Younger ready match masks older pending match
        clear_fwd();
        new_instr(5'd9, 5'd4, 5'd6);
        set_fwd(0, 1'b1, 1'b0, 5'd9, 32'h55);
        set_fwd(2, 1'b1, 1'b1, 5'd9, 32'h77);
        cycle();
        check_val("mask.rd1", out_rd1, 32'h55);

        // Load-use on rs2 for three cycles, then data arrives
        clear_fwd();
        new_instr(5'd1, 5'd7, 5'd8);
        set_fwd(1, 1'b1, 1'b1, 5'd7, 32'h0);
        repeat (3) cycle();
        check_val("loaduse.stall_cnt", stall_cnt, 2'd3);
        set_fwd(1, 1'b1, 1'b0, 5'd7, 32'h42);
        cycle();
        check_val("loaduse.rd2", out_rd2, 32'h42);

        // Backpressure: stage holds, new input waits, then loads on release
        clear_fwd();
        new_instr(5'd2, 5'd3, 5'd4);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        new_instr(5'd10, 5'd11, 5'd12);
        repeat (4) cycle();
        check_val("bp.in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        cycle();
        check_val("bp.loaded_pc", out_pc, pc_in);

        // Flush beats a pending input; the input is taken afterwards
        out_ready = 1'b0;
        new_instr(5'd13, 5'd14, 5'd15);
        flush = 1'b1;
        cycle();
        check_val("flush.valid", out_valid, 1'b0);
        check_val("flush.flush_cnt", flush_cnt, 2'd1);
        flush = 1'b0;
        out_ready = 1'b1;
        cycle();
        check_val("flush.retry_pc", out_pc, pc_in);

        // Mixed random traffic on a small register window
        for (int n = 0; n < 40; n++) begin
            new_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NFWD; i++)
                set_fwd(i, 1'($urandom), ($urandom_range(0, 3) == 0),
                        5'($urandom_range(0, 3)), $urandom);
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset between edges clears everything at once
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst1");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Stall counter saturates at its maximum
        clear_fwd();
        out_ready = 1'b1;
        new_instr(5'd6, 5'd0, 5'd1);
        set_fwd(2, 1'b1, 1'b1, 5'd6, 32'h0);
        repeat (5) cycle();
        check_val("sat.stall_cnt", stall_cnt, 2'd3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst2");
        model_reset();

        // Release reset while an instruction is offered; it lands one edge later
        clear_fwd();
        new_instr(5'd3, 5'd4, 5'd5);
        @(posedge clk);
        #1;
        check_val("rst_hold.valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check_val("rst_rel.valid", out_valid, 1'b1);
        check_val("rst_rel.pc", out_pc, pc_in);

        in_valid = 1'b0;
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
